// File: rtl/neuron_mac.sv
// neuron_mac: sequential multiply-accumulate neuron.
// Latches an M-element packed input vector, weights and bias on start.
// It multiplies one element per clock into a wide accumulator, then adds
// the bias and rescales. The result is saturated to N bits, with an
// optional ReLU.
//
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high reset
//   start - compute request, honoured only while idle
//   x     - packed inputs, element i = x[i*N +: N]
//   w     - packed weights, same packing as x
//   b     - bias, Q(N-FRAC).FRAC
//   y     - registered saturated result
//   busy  - high while a computation is in flight
//   done  - one-cycle pulse when y is updated
module neuron_mac #(
  parameter int M    = 4,
  parameter int N    = 32,
  parameter int FRAC = 16,
  parameter int RELU = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [M*N-1:0] x,
  input  logic [M*N-1:0] w,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   y,
  output logic           busy,
  output logic           done
);

  // Wide enough that M full-precision products plus the shifted bias
  // cannot overflow before saturation.
  localparam int AW = 2*N + $clog2(M) + 1;
  localparam int IW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE, MAC, FIN} state_t;

  state_t state, state_nx;

  logic signed [N-1:0]    xl [M];
  logic signed [N-1:0]    wl [M];
  logic signed [N-1:0]    bl;
  logic        [IW-1:0]   idx;
  logic signed [AW-1:0]   acc;

  logic                   last;
  logic signed [2*N-1:0]  xe, we, prod;
  logic signed [AW-1:0]   prod_ext, bias_ext, sum, r;
  logic        [AW-N:0]   hi;
  logic        [N-1:0]    res;

  assign last = (idx == IW'(M-1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = MAC;
      MAC:     if (last)  state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // Full-precision product of the current element pair
  always_comb begin
    xe       = {{N{xl[idx][N-1]}}, xl[idx]};
    we       = {{N{wl[idx][N-1]}}, wl[idx]};
    prod     = xe * we;
    prod_ext = {{(AW-2*N){prod[2*N-1]}}, prod};
  end

  // Bias alignment, rescale (floor), saturation and optional ReLU
  always_comb begin
    bias_ext = {{(AW-N){bl[N-1]}}, bl};
    sum      = acc + (bias_ext <<< FRAC);
    r        = sum >>> FRAC;
    // In range iff every bit from N-1 upward matches the sign.
    hi       = r[AW-1:N-1];
    if (hi == '0 || hi == '1) res = r[N-1:0];
    else if (r[AW-1])         res = {1'b1, {(N-1){1'b0}}};
    else                      res = {1'b0, {(N-1){1'b1}}};
    if (RELU != 0 && res[N-1]) res = '0;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < M; i++) begin
        xl[i] <= '0;
        wl[i] <= '0;
      end
      bl   <= '0;
      acc  <= '0;
      idx  <= '0;
      y    <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < M; i++) begin
              xl[i] <= x[i*N +: N];
              wl[i] <= w[i*N +: N];
            end
            bl  <= b;
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          idx <= last ? '0 : idx + 1'b1;
        end
        FIN: begin
          y    <= res;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed self-checking bench for neuron_mac.
// Three instances are used. The first has the default parameters. The
// second has RELU=1 and shares its inputs with the first. The third has
// M=1, N=8 and FRAC=4.
module tb_neuron_mac;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] x = '0;
  logic [127:0] w = '0;
  logic [31:0]  b = '0;
  logic [31:0]  y, y_r;
  logic         busy, done, busy_r, done_r;

  logic         start1 = 1'b0;
  logic [7:0]   x1 = '0, w1 = '0, b1 = '0, y1;
  logic         busy1, done1;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  neuron_mac #(.M(4), .N(32), .FRAC(16), .RELU(0)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .w(w), .b(b),
    .y(y), .busy(busy), .done(done)
  );

  neuron_mac #(.M(4), .N(32), .FRAC(16), .RELU(1)) dut_r (
    .clk(clk), .rst(rst), .start(start), .x(x), .w(w), .b(b),
    .y(y_r), .busy(busy_r), .done(done_r)
  );

  neuron_mac #(.M(1), .N(8), .FRAC(4), .RELU(0)) dut_m1 (
    .clk(clk), .rst(rst), .start(start1), .x(x1), .w(w1), .b(b1),
    .y(y1), .busy(busy1), .done(done1)
  );

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Operand sets
  localparam logic [127:0] X_BASIC = {32'h00008000, 32'hFFFF0000, 32'h00020000, 32'h00010000};
  localparam logic [127:0] W_ONES  = {4{32'h00010000}};
  localparam logic [127:0] X_BIAS  = {32'h0, 32'h0, 32'h0, 32'h00010000};
  localparam logic [127:0] W_BIAS  = {32'h0, 32'h0, 32'h0, 32'hFFFD0000};
  localparam logic [127:0] MAXV    = {4{32'h7FFFFFFF}};
  localparam logic [127:0] MINV    = {4{32'h80000000}};

  // Starts an operation, scrambles the inputs right after the start edge,
  // then waits for done and checks latency, busy length and both results.
  // With b2b set, start is driven in the current cycle (the done cycle).
  task automatic run_op(input string tag, input bit b2b,
                        input logic [127:0] xv, input logic [127:0] wv,
                        input logic [31:0] bv, input logic [31:0] ey,
                        input logic [31:0] ey_r);
    int lat, bc;
    if (!b2b) @(negedge clk);
    x = xv; w = wv; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = ~xv; w = ~wv; b = ~bv;
    bc  = busy ? 1 : 0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      if (busy) bc++;
    end
    check({tag, " latency"}, lat, 5);
    check({tag, " busy_len"}, bc, 5);
    check({tag, " y"}, y, ey);
    check({tag, " y_relu"}, y_r, ey_r);
  endtask

  initial begin
    int d0, lat;
    logic [7:0] m1x [2];
    logic [7:0] m1w [2];
    logic [7:0] m1b [2];
    logic [7:0] m1y [2];

    // Reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("idle y", y, 32'h0);
    check("idle busy", {31'b0, busy}, 32'h0);
    check("idle done_cnt", done_cnt, 0);

    // Basic dot product then back-to-back bias/negative case
    run_op("basic", 1'b0, X_BASIC, W_ONES, 32'h0, 32'h00028000, 32'h00028000);
    run_op("bias_b2b", 1'b1, X_BIAS, W_BIAS, 32'h00010000, 32'hFFFE0000, 32'h0);

    // Saturation in both directions
    run_op("sat_pos", 1'b0, MAXV, MAXV, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    run_op("sat_neg", 1'b0, MAXV, MINV, 32'h7FFFFFFF, 32'h80000000, 32'h0);

    // Start while busy is ignored and not queued
    @(negedge clk);
    #1 d0 = done_cnt;
    x = X_BASIC; w = W_ONES; b = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    x = MAXV; w = MAXV; b = 32'h7FFFFFFF; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    check("ignore done_seen", {31'b0, lat >= 0}, 32'h1);
    check("ignore y", y, 32'h00028000);
    repeat (10) @(negedge clk);
    #1;
    check("ignore done_cnt", done_cnt - d0, 1);
    check("ignore busy", {31'b0, busy}, 32'h0);

    // Reset in the middle of MAC aborts with no done
    @(negedge clk);
    x = MAXV; w = MAXV; b = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("rst busy", {31'b0, busy}, 32'h0);
    check("rst y", y, 32'h0);
    check("rst done", {31'b0, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("rst no_done", done_cnt - d0, 0);
    run_op("after_rst", 1'b0, X_BASIC, W_ONES, 32'h0, 32'h00028000, 32'h00028000);

    // M=1 instance (Q4.4): saturating min*min, and 1.5*2.0+1.0 = 4.0
    m1x[0] = 8'h80; m1w[0] = 8'h80; m1b[0] = 8'h00; m1y[0] = 8'h7F;
    m1x[1] = 8'h18; m1w[1] = 8'h20; m1b[1] = 8'h10; m1y[1] = 8'h40;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      x1 = m1x[k]; w1 = m1w[k]; b1 = m1b[k]; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; x1 = 8'h00; w1 = 8'h00;
      lat = -1;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (done1) begin
          lat = c;
          break;
        end
      end
      check("m1 latency", lat, 2);
      check("m1 y", {24'h0, y1}, {24'h0, m1y[k]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Sequential multiply-accumulate neuron, directly downstream of the parametric-layer input shift register.
- Consumes the m·n-bit packed input vector that the shift register produces once m words have been shifted in.
- Multiplies each element by its weight, one element per clock, then adds a bias and applies an optional ReLU.
- Emits one saturated n-bit signed fixed-point result with a done pulse.

Parameters:
- M, 4, number of input elements (matches shift register m)
- N, 32, element/weight/bias/result width, signed two's complement
- FRAC, 16, fractional bits of the Q(N-FRAC).FRAC format; 0 ≤ FRAC < N
- RELU, 0, 1 = clamp negative results to 0; 0 = identity

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request to compute; sampled at posedge clk, honoured only when busy=0
- x  in  M*N  packed inputs; element i = x[i*N +: N]; element 0 = oldest shifted-in word (LSB slot)
- w  in  M*N  packed weights, same packing as x
- b  in  N  bias, same Q format
- y  out  N  result, registered
- busy  out  1  high while a computation is in flight
- done  out  1  one-cycle pulse; y is valid from this cycle on

Behaviour:
- Reset: asynchronous, active-high; clock clk. While rst=1: state=IDLE, y=0, busy=0, done=0, accumulator=0, index=0.
- FSM states: IDLE, MAC, FIN.
- IDLE: on an edge with start=1:
  - latch x, w, b into internal registers;
  - clear the accumulator; index=0;
  - busy=1; go to MAC.
  - Inputs may change freely after this edge.
- MAC: on each edge, acc += sext(xl[index]) * sext(wl[index]) at full 2N-bit product precision; index++.
  - After the edge that processes index=M-1, go to FIN.
  - MAC lasts exactly M cycles.
- FIN: on the edge:
  - r = (acc + (sext(bl) << FRAC)) >>> FRAC, an arithmetic shift that truncates toward -inf;
  - saturate r to [-2^(N-1), 2^(N-1)-1];
  - if RELU=1 and the result is negative, result = 0;
  - y <= result; done=1; busy=0; go to IDLE.
- Accumulator width: 2N + clog2(M) + 1 bits; overflow is impossible before saturation.
- Latency: start sampled at edge 0 → done and new y visible after edge M+1, i.e. M+1 cycles start-to-done.
- Pipelining and hold behaviour:
  - done lasts exactly one cycle.
  - y holds its value until the next FIN edge.
  - Non-overlapping only: throughput is one result per M+1 cycles.
- Boundary conditions:
  - start while busy=1 is ignored; it is not queued.
  - start asserted in the cycle done=1 (state IDLE) is accepted, giving back-to-back operation with no bubble beyond FIN.
  - start held high continuously restarts on every IDLE cycle.
  - rst asserted mid-MAC or mid-FIN aborts immediately: all outputs return to reset values and no done is issued.
  - M=1 is legal: MAC lasts one cycle.
  - Most-negative × most-negative is handled by the full-precision product.

Test Plan:
- Reset/idle: assert rst, then release with start=0 for 10 cycles → y=0, busy=0, done never asserted.
- Basic dot product (defaults):
  - Stimulus: x = {0x00010000, 0x00020000, 0xFFFF0000, 0x00008000} (1, 2, -1, 0.5); w all 0x00010000; b = 0.
  - Required: done exactly 5 cycles after the start edge, y = 0x00028000 (2.5), busy high for 5 cycles.
- Bias and negative, RELU=0:
  - Stimulus: x = {1, 0, 0, 0} (Q), w0 = 0xFFFD0000 (-3), b = 0x00010000.
  - Required: y = 0xFFFE0000 (-2).
  - Same stimulus with RELU=1 → y = 0.
- Saturation:
  - Stimulus: all x and all w = 0x7FFFFFFF, b = 0x7FFFFFFF.
  - Required: y = 0x7FFFFFFF.
  - Same with w = 0x80000000 → y = 0x80000000.
- Handshake:
  - Pulse start, then pulse it again at cycles 2 and 3 → ignored, exactly one done.
  - Assert start in the done cycle with new operands → second done exactly 5 cycles later with the new result.
  - Changing x the cycle after start does not alter the result.
- Reset mid-operation: start, then assert rst at cycle 3 → busy=0, y=0 immediately, no done; a fresh start afterwards produces a correct result.
